// File: rtl/gbox_pkg.sv
// Shared constants and types for the 64b/66b transmit gearbox.
package gbox_pkg;

    localparam logic [1:0]  C_DATA_HEADER  = 2'b01;
    localparam logic [1:0]  C_CMD_HEADER   = 2'b10;
    localparam logic [63:0] C_IDLE_PAYLOAD = 64'h7800_0000_0000_0000;

    localparam int C_BUF_W  = 130;
    localparam int C_WORD_W = 32;
    localparam int C_BLK_W  = 66;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } block_t;

    localparam block_t C_IDLE_BLOCK = '{hdr: C_CMD_HEADER, data: C_IDLE_PAYLOAD};

    typedef enum logic {
        INIT,
        RUN
    } gbox_state_t;

endpackage

// File: rtl/scrambler58.sv
// Self-synchronous x^58 + x^39 + 1 payload scrambler, bit 63 first.
// The state holds the most recent 58 scrambled bits and advances only when enabled.
module scrambler58 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable,
    input  logic [63:0] payload,
    output logic [63:0] scrambled
);

    logic [57:0] state_q;
    logic [57:0] state_d;

    always_comb begin
        state_d   = state_q;
        scrambled = '0;
        for (int i = 63; i >= 0; i--) begin
            scrambled[i] = payload[i] ^ state_d[38] ^ state_d[57];
            state_d      = {state_d[56:0], scrambled[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '1;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/gearbox66_tx.sv
// Transmit 66b->32b gearbox with idle training after reset and idle fill on underrun.
// Define GBOX_TX_SCRAMBLE_EN to scramble block payloads before they enter the line buffer.
module gearbox66_tx
    import gbox_pkg::*;
#(
    parameter int INIT_BLOCKS = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  blk_hdr_i,
    input  logic [63:0] blk_data_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        init_done_o,
    output logic        idle_ins_o
);

    localparam int IDLE_W = $clog2(INIT_BLOCKS + 1);

    gbox_state_t          state_q, state_d;
    logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic [C_BUF_W-1:0]   shift_q, shift_d;
    logic [C_BUF_W-1:0]   shifted, placed;
    logic [7:0]           cnt_q, cnt_d, cnt_post;
    logic                 emit, space, load, load_idle;
    block_t               blk_sel;
    logic [63:0]          load_payload;

    assign word_valid_o = (cnt_q >= 8'd32);
    assign word_o       = shift_q[C_BUF_W-1 -: C_WORD_W];
    assign emit         = word_valid_o & word_ready_i;
    assign space        = (cnt_q <= 8'd64);
    assign cnt_post     = emit ? cnt_q - 8'd32 : cnt_q;
    assign init_done_o  = (state_q == RUN);

    // Idle insertion in RUN only when the post-emit fill could not cover next cycle's word.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        blk_ready_o = 1'b0;
        load        = 1'b0;
        load_idle   = 1'b0;
        idle_ins_o  = 1'b0;
        case (state_q)
            INIT: begin
                if (space) begin
                    load       = 1'b1;
                    load_idle  = 1'b1;
                    idle_cnt_d = idle_cnt_q + 1'b1;
                    if (idle_cnt_q == IDLE_W'(INIT_BLOCKS - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                blk_ready_o = space;
                if (blk_valid_i && space) begin
                    load = 1'b1;
                end else if (!blk_valid_i && space && (cnt_post < 8'd32)) begin
                    load       = 1'b1;
                    load_idle  = 1'b1;
                    idle_ins_o = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        blk_sel = C_IDLE_BLOCK;
        if (!load_idle) begin
            blk_sel = '{hdr: blk_hdr_i, data: blk_data_i};
        end
    end

`ifdef GBOX_TX_SCRAMBLE_EN
    scrambler58 u_scrambler (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .enable    (load),
        .payload   (blk_sel.data),
        .scrambled (load_payload)
    );
`else
    assign load_payload = blk_sel.data;
`endif

    // Bits beyond the fill count are always zero, so a new block can simply be OR-ed in.
    assign shifted = emit ? (shift_q << C_WORD_W) : shift_q;
    assign placed  = {blk_sel.hdr, load_payload, 64'b0} >> cnt_post;
    assign shift_d = load ? (shifted | placed) : shifted;
    assign cnt_d   = load ? cnt_post + 8'd66 : cnt_post;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            idle_cnt_q <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gearbox66_tx.sv
// Randomized bench for gearbox66_tx against a bit-queue model of the transmitted line.
module tb_gearbox66_tx;
    import gbox_pkg::*;

    localparam int INIT_BLOCKS = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  blk_hdr_i;
    logic [63:0] blk_data_i;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;
    logic        init_done_o;
    logic        idle_ins_o;

    int check_count = 0;
    int pass_count  = 0;

    bit line_q[$];
    int init_loaded;
`ifdef GBOX_TX_SCRAMBLE_EN
    bit scr_hist[$];
`endif

    gearbox66_tx #(.INIT_BLOCKS(INIT_BLOCKS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .blk_hdr_i    (blk_hdr_i),
        .blk_data_i   (blk_data_i),
        .blk_valid_i  (blk_valid_i),
        .blk_ready_o  (blk_ready_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .init_done_o  (init_done_o),
        .idle_ins_o   (idle_ins_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        init_loaded = 0;
`ifdef GBOX_TX_SCRAMBLE_EN
        scr_hist.delete();
        for (int i = 0; i < 58; i++) scr_hist.push_back(1'b1);
`endif
    endtask

    // Appends one block to the expected line, header first, payload bit 63 first.
    task automatic push_block(input logic [1:0] hdr, input logic [63:0] data);
        bit b;
        line_q.push_back(hdr[1]);
        line_q.push_back(hdr[0]);
        for (int i = 63; i >= 0; i--) begin
            b = data[i];
`ifdef GBOX_TX_SCRAMBLE_EN
            b = b ^ scr_hist[scr_hist.size() - 39] ^ scr_hist[scr_hist.size() - 58];
            scr_hist.push_back(b);
            void'(scr_hist.pop_front());
`endif
            line_q.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_word"},       64'(word_o),       64'd0);
        checkOutput({tag, "_word_valid"}, 64'(word_valid_o), 64'd0);
        checkOutput({tag, "_blk_ready"},  64'(blk_ready_o),  64'd0);
        checkOutput({tag, "_init_done"},  64'(init_done_o),  64'd0);
        checkOutput({tag, "_idle_ins"},   64'(idle_ins_o),   64'd0);
    endtask

    // Drives one cycle, checks the DUT against the model, then advances the model.
    task automatic applyStimulus(input logic v, input logic [1:0] h, input logic [63:0] d, input logic wr,
                                 output logic accepted, output logic ins, output logic wvalid, output logic ready);
        logic        exp_valid, exp_ready, exp_ins, emit, space, run, push_up, push_idle;
        logic [31:0] exp_word;
        int          post;
        @(negedge clk_i);
        blk_valid_i  = v;
        blk_hdr_i    = h;
        blk_data_i   = d;
        word_ready_i = wr;
        #1;
        exp_valid = (line_q.size() >= 32);
        emit      = exp_valid && wr;
        space     = (line_q.size() <= 64);
        run       = (init_loaded >= INIT_BLOCKS);
        exp_ready = run && space;
        post      = line_q.size() - (emit ? 32 : 0);
        push_up   = run && v && space;
        push_idle = run ? (!v && space && post < 32) : space;
        exp_ins   = run && push_idle;
        exp_word  = '0;
        if (exp_valid) begin
            for (int i = 0; i < 32; i++) exp_word[31-i] = line_q[i];
        end
        checkOutput("word_valid", 64'(word_valid_o), 64'(exp_valid));
        if (exp_valid) checkOutput("word", 64'(word_o), 64'(exp_word));
        checkOutput("blk_ready", 64'(blk_ready_o), 64'(exp_ready));
        checkOutput("init_done", 64'(init_done_o), 64'(run));
        checkOutput("idle_ins",  64'(idle_ins_o),  64'(exp_ins));
        accepted = blk_ready_o && v;
        ins      = idle_ins_o;
        wvalid   = word_valid_o;
        ready    = blk_ready_o;
        if (emit) begin
            for (int i = 0; i < 32; i++) void'(line_q.pop_front());
        end
        if (push_up) push_block(h, d);
        if (push_idle) push_block(C_CMD_HEADER, C_IDLE_PAYLOAD);
        if (!run && push_idle) init_loaded++;
    endtask

    initial begin
        logic acc, ins, wv, rdy;
        int   n_acc, n_ins, n_drop, n_rdy_low;

        rst_ni       = 1'b0;
        blk_valid_i  = 1'b0;
        blk_hdr_i    = 2'b00;
        blk_data_i   = '0;
        word_ready_i = 1'b1;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;

        // Training: upstream offers blocks but only idles may go out.
        for (int c = 0; c < 150; c++) begin
            applyStimulus(1'b1, C_DATA_HEADER, {$urandom, $urandom}, 1'b1, acc, ins, wv, rdy);
        end
        checkOutput("init_done_after_training", 64'(init_done_o), 64'd1);

        // Continuous data blocks with a free-running serializer.
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, C_DATA_HEADER, 64'h0123_4567_89AB_CDEF, 1'b1, acc, ins, wv, rdy);
        end
        n_acc = 0; n_ins = 0; n_rdy_low = 0;
        for (int c = 0; c < 33; c++) begin
            applyStimulus(1'b1, C_DATA_HEADER, 64'h0123_4567_89AB_CDEF, 1'b1, acc, ins, wv, rdy);
            n_acc += int'(acc);
            n_ins += int'(ins);
            n_rdy_low += int'(!rdy);
        end
        checkOutput("steady_accepts_per_33", 64'(n_acc), 64'd16);
        checkOutput("steady_idle_ins", 64'(n_ins), 64'd0);
        checkOutput("steady_ready_drops", 64'(n_rdy_low > 0), 64'd1);

        // Upstream starved: idles fill the line.
        n_ins = 0; n_drop = 0;
        for (int c = 0; c < 100; c++) begin
            applyStimulus(1'b0, 2'b00, {$urandom, $urandom}, 1'b1, acc, ins, wv, rdy);
            n_ins += int'(ins);
            n_drop += int'(!wv);
        end
        checkOutput("starve_idle_ins_seen", 64'(n_ins > 0), 64'd1);
        checkOutput("starve_word_valid_drops", 64'(n_drop), 64'd0);

        // Serializer stall then release.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 2'($urandom), {$urandom, $urandom}, 1'b0, acc, ins, wv, rdy);
        end
        checkOutput("stall_ready_low", 64'(rdy), 64'd0);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 2'($urandom), {$urandom, $urandom}, 1'b1, acc, ins, wv, rdy);
        end

        // Random traffic, including illegal headers.
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, 2'($urandom), {$urandom, $urandom},
                          $urandom_range(0, 19) < 17, acc, ins, wv, rdy);
        end

        // Reset in the middle of a cycle, then retrain.
        @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        for (int c = 0; c < 150; c++) begin
            applyStimulus(1'b0, 2'b00, '0, 1'b1, acc, ins, wv, rdy);
        end
        checkOutput("init_done_after_retrain", 64'(init_done_o), 64'd1);
        for (int c = 0; c < 200; c++) begin
            applyStimulus($urandom_range(0, 1) == 1, C_DATA_HEADER, {$urandom, $urandom},
                          $urandom_range(0, 9) < 9, acc, ins, wv, rdy);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/gearbox66_tx.md
# gearbox66_tx

Transmit-side 64b/66b gearbox: accepts 66-bit blocks (2-bit sync header + 64-bit payload) over a valid/ready handshake and emits a continuous MSB-first stream of 32-bit words toward the serializer. It is the transmit counterpart of the receive-side header seeker and 66b gearbox. After reset it sends a run of idle blocks so the far-end header seeker can lock. Whenever the upstream has no block ready, it inserts idle blocks so the line never underruns.

## Interface
- INIT_BLOCKS, 64: idle blocks forced after reset before upstream blocks are accepted (≥63 so the far-end seeker saturates its lock count)
- clk_i  in  1  system clock; one clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- blk_hdr_i  in  2  sync header (01 data, 10 command)
- blk_data_i  in  64  block payload
- blk_valid_i  in  1  block present
- blk_ready_o  out  1  block accepted when high with blk_valid_i
- word_o  out  32  line word; bit 31 transmitted first
- word_valid_o  out  1  word_o holds 32 valid bits
- word_ready_i  in  1  serializer consumes word_o this cycle
- init_done_o  out  1  high once INIT completes
- idle_ins_o  out  1  one-cycle pulse when a RUN-state idle block is inserted

## Operation
- Storage: 130-bit left-aligned shift buffer plus fill count cnt (0..130). Valid bits occupy buf[129 -: cnt].
- Emit: emit = word_valid_o & word_ready_i, with word_valid_o = (cnt ≥ 32). word_o = buf[129:98]. On emit the buffer shifts left by 32 and cnt_post = cnt − 32; otherwise cnt_post = cnt.
- Space: space = (cnt ≤ 64). Space is evaluated on the registered cnt, independent of emit.
- Load: the block {hdr, payload} is written at buf[129−cnt_post -: 66], and cnt_next = cnt_post + 66.
- FSM, INIT (reset state):
  - blk_ready_o = 0.
  - An idle block is loaded on every cycle with space.
  - An idle counter counts loaded blocks; at INIT_BLOCKS the FSM moves to RUN.
- FSM, RUN:
  - blk_ready_o = space.
  - Upstream load when blk_valid_i & space.
  - If !blk_valid_i & space & cnt_post < 32, an idle block is loaded and idle_ins_o pulses.
  - RUN is never left except by reset.
- Idle block: hdr 2'b10, payload 64'h7800_0000_0000_0000.
- Header legality: illegal headers (00/11) are passed unchanged; header checking is not this block's job.
- Word stall: word_ready_i low holds buffer and cnt except for loads. Once cnt > 64, loads stop, so the buffer cannot overflow.
- Reset mid-operation clears buffer, cnt, counters and FSM immediately. Any partial block in the buffer is discarded.
- Outputs at reset: blk_ready_o 0, word_o 0, word_valid_o 0, init_done_o 0, idle_ins_o 0.

## Timing
- Block accepted at cycle t with cnt = 0: its header bits appear at word_o[31:30] in cycle t+1.
- Steady state with word_ready_i held high:
  - one word per cycle;
  - 16 blocks accepted per 33 cycles;
  - blk_ready_o drops at least once every 33 cycles.
- First word_valid_o occurs in the cycle after reset release plus one (the first idle load).
- INIT lasts until INIT_BLOCKS idles are loaded (≈ INIT_BLOCKS × 33/16 cycles). init_done_o rises in the cycle after the last INIT load.

## Configuration
- GBOX_TX_SCRAMBLE_EN defined:
  - Payload (never header) passes through a self-synchronous scrambler, polynomial x^58 + x^39 + 1, before load.
  - Scrambler state is 58 bits, reset to all ones, and advances only on loaded blocks (idle and upstream).
  - Payload bit 63 is scrambled first.
- Undefined: payload is loaded unmodified.

## Structure
- Shared package gbox_pkg holds:
  - C_DATA_HEADER = 2'b01, C_CMD_HEADER = 2'b10;
  - C_IDLE_PAYLOAD;
  - the block typedef (struct hdr[1:0], data[63:0]);
  - the FSM state enum {INIT, RUN}.
- Sub-module scrambler58 (combinational 64-bit step plus registered state, enable input) is instantiated only under GBOX_TX_SCRAMBLE_EN.

## Test plan
- Reset, word_ready_i=1, INIT_BLOCKS=64:
  - exactly 64 idle blocks appear on the line (hdr 10, payload 7800…00);
  - blk_ready_o stays 0 until init_done_o rises.
- RUN, continuous blocks hdr 01 / payload 0123_4567_89AB_CDEF:
  - a receiver-side re-assembly of the word stream finds a 66-bit period;
  - 16 blocks accepted per 33 words, no idle_ins_o.
- RUN, blk_valid_i held low for 100 cycles:
  - idle_ins_o pulses;
  - word_valid_o never drops;
  - only idle blocks appear.
- word_ready_i low for 10 cycles:
  - cnt saturates ≤ 130 and blk_ready_o goes 0;
  - no bits are lost or duplicated after release.
- rst_ni asserted mid-block: all outputs go 0 immediately, and INIT restarts on release.
- GBOX_TX_SCRAMBLE_EN, all-zero payloads after reset:
  - line payload equals the scrambler's all-ones-seed sequence;
  - headers are unscrambled.
